// File: rtl/hbm_multi_port_read_arbiter.sv
// Round-robin sharing of one HBM AXI4 read channel among several edge-read ports.
// Each granted request becomes one AR burst; an in-order tag FIFO steers R beats back to its owner.
module hbm_multi_port_read_arbiter #(
    parameter int C_NUM_PORTS        = 4,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_BURST_LEN        = 1,
    parameter int C_MAX_OUTSTANDING  = 16
) (
    input  logic                                      aclk,
    input  logic                                      areset_n,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]             ctrl_addr_offset,
    input  logic [C_NUM_PORTS*C_M_AXI_ADDR_WIDTH-1:0] port_req_addr,
    input  logic [C_NUM_PORTS-1:0]                    port_req_valid,
    output logic [C_NUM_PORTS-1:0]                    port_req_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]             port_resp_data,
    output logic [C_NUM_PORTS-1:0]                    port_resp_valid,
    output logic                                      port_resp_last,
    input  logic [C_NUM_PORTS-1:0]                    port_resp_ready,
    output logic                                      m_axi_arvalid,
    input  logic                                      m_axi_arready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]             m_axi_araddr,
    output logic [7:0]                                m_axi_arlen,
    input  logic                                      m_axi_rvalid,
    output logic                                      m_axi_rready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]             m_axi_rdata,
    input  logic                                      m_axi_rlast,
    output logic [$clog2(C_MAX_OUTSTANDING):0]        outstanding,
    output logic                                      idle,
    output logic                                      rresp_err
);

    localparam int PW  = $clog2(C_NUM_PORTS);
    localparam int TW  = $clog2(C_MAX_OUTSTANDING);
    localparam int OW  = TW + 1;
    localparam int LSB = $clog2(C_M_AXI_DATA_WIDTH / 8);
    localparam int AW  = C_M_AXI_ADDR_WIDTH;

    logic [PW-1:0] rr_ptr_r;
    logic          ar_valid_r;
    logic [AW-1:0] ar_addr_r;
    logic [OW-1:0] outstanding_r;
    logic [TW-1:0] wr_ptr_r;
    logic [TW-1:0] rd_ptr_r;
    logic          rresp_err_r;
    logic [PW-1:0] tag_mem_r [C_MAX_OUTSTANDING];

    logic          grant_en_s;
    logic          win_found_s;
    logic [PW-1:0] win_idx_s;
    logic          accept_s;
    logic [AW-1:0] addr_sum_s;
    logic [AW-1:0] ar_addr_next_s;
    logic          empty_s;
    logic [PW-1:0] head_s;
    logic          pop_s;

    // Port index reached by stepping off positions forward from base, wrapping at C_NUM_PORTS.
    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= C_NUM_PORTS) begin
            s = s - C_NUM_PORTS;
        end else begin
            s = s;
        end
        return PW'(s);
    endfunction

    // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign grant_en_s = areset_n && (!ar_valid_r || m_axi_arready) &&
                        (outstanding_r < OW'(C_MAX_OUTSTANDING));

    // Scan from the far end back toward rr so the last hit is the first valid port at/after rr.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        for (int i = C_NUM_PORTS - 1; i >= 0; i--) begin
            if (port_req_valid[wrap_idx(rr_ptr_r, i)]) begin
                win_found_s = 1'b1;
                win_idx_s   = wrap_idx(rr_ptr_r, i);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    assign accept_s       = grant_en_s && win_found_s;
    assign addr_sum_s     = ctrl_addr_offset + port_req_addr[int'(win_idx_s)*AW +: AW];
    assign ar_addr_next_s = {addr_sum_s[AW-1:LSB], {LSB{1'b0}}};

    // One-hot grant to the arbitration winner.
    always_comb begin
        port_req_ready = '0;
        if (accept_s) begin
            port_req_ready[win_idx_s] = 1'b1;
        end else begin
            port_req_ready = '0;
        end
    end

    assign empty_s = (outstanding_r == '0);
    assign head_s  = tag_mem_r[rd_ptr_r];

    // Steer the R channel to the port owning the oldest outstanding burst.
    always_comb begin
        port_resp_valid = '0;
        m_axi_rready    = 1'b0;
        if (!empty_s) begin
            port_resp_valid[head_s] = m_axi_rvalid;
            m_axi_rready            = port_resp_ready[head_s];
        end else begin
            m_axi_rready = 1'b0;
        end
    end

    assign pop_s = m_axi_rvalid && m_axi_rready && m_axi_rlast;

    // Control state: AR slot, round-robin pointer, FIFO pointers, in-flight count, error flag.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            rr_ptr_r      <= '0;
            ar_valid_r    <= 1'b0;
            ar_addr_r     <= '0;
            outstanding_r <= '0;
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            rresp_err_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                ar_valid_r <= 1'b1;
                ar_addr_r  <= ar_addr_next_s;
                rr_ptr_r   <= wrap_idx(win_idx_s, 1);
                wr_ptr_r   <= wr_ptr_r + TW'(1);
            end else if (m_axi_arready) begin
                ar_valid_r <= 1'b0;
            end else begin
                ar_valid_r <= ar_valid_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + TW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({accept_s, pop_s})
                2'b10:   outstanding_r <= outstanding_r + OW'(1);
                2'b01:   outstanding_r <= outstanding_r - OW'(1);
                default: outstanding_r <= outstanding_r;
            endcase
            if (m_axi_rvalid && empty_s) begin
                rresp_err_r <= 1'b1;
            end else begin
                rresp_err_r <= rresp_err_r;
            end
        end
    end

    // Tag storage needs no reset; entries are only read behind a valid write.
    always_ff @(posedge aclk) begin
        if (accept_s) begin
            tag_mem_r[wr_ptr_r] <= win_idx_s;
        end
    end

    assign m_axi_arvalid  = ar_valid_r;
    assign m_axi_araddr   = ar_addr_r;
    assign m_axi_arlen    = 8'(C_BURST_LEN - 1);
    assign port_resp_data = m_axi_rdata;
    assign port_resp_last = m_axi_rlast;
    assign outstanding    = outstanding_r;
    assign idle           = empty_s && !ar_valid_r;
    assign rresp_err      = rresp_err_r;

endmodule

// File: tb/tb_hbm_multi_port_read_arbiter.sv
// Directed bench for hbm_multi_port_read_arbiter: queue-based reference model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_hbm_multi_port_read_arbiter;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 512;
    localparam int BL = 4;
    localparam int MO = 16;
    localparam int OW = 5;

    logic            clk = 1'b0;
    logic            areset_n;
    logic [AW-1:0]   ctrl_addr_offset;
    logic [N*AW-1:0] port_req_addr;
    logic [N-1:0]    port_req_valid;
    logic [N-1:0]    port_req_ready;
    logic [DW-1:0]   port_resp_data;
    logic [N-1:0]    port_resp_valid;
    logic            port_resp_last;
    logic [N-1:0]    port_resp_ready;
    logic            m_axi_arvalid;
    logic            m_axi_arready;
    logic [AW-1:0]   m_axi_araddr;
    logic [7:0]      m_axi_arlen;
    logic            m_axi_rvalid;
    logic            m_axi_rready;
    logic [DW-1:0]   m_axi_rdata;
    logic            m_axi_rlast;
    logic [OW-1:0]   outstanding;
    logic            idle;
    logic            rresp_err;

    always #5 clk = ~clk;

    hbm_multi_port_read_arbiter #(
        .C_NUM_PORTS(N), .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW),
        .C_BURST_LEN(BL), .C_MAX_OUTSTANDING(MO)
    ) dut (
        .aclk(clk), .areset_n(areset_n), .ctrl_addr_offset(ctrl_addr_offset),
        .port_req_addr(port_req_addr), .port_req_valid(port_req_valid),
        .port_req_ready(port_req_ready), .port_resp_data(port_resp_data),
        .port_resp_valid(port_resp_valid), .port_resp_last(port_resp_last),
        .port_resp_ready(port_resp_ready), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
        .m_axi_rlast(m_axi_rlast), .outstanding(outstanding), .idle(idle),
        .rresp_err(rresp_err)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: queue of owning ports in AR order, pending AR slot, rr pointer, error flag.
    int          q[$];
    int          m_rr = 0;
    bit          m_ar_pend = 1'b0;
    logic [63:0] m_ar_addr = 64'd0;
    bit          m_err = 1'b0;

    function automatic int exp_winner();
        if (!areset_n) return -1;
        if (m_ar_pend && !m_axi_arready) return -1;
        if (q.size() >= MO) return -1;
        for (int i = 0; i < N; i++) begin
            if (port_req_valid[(m_rr + i) % N]) return (m_rr + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [63:0] exp_addr(input int p);
        logic [63:0] s;
        s = ctrl_addr_offset + port_req_addr[p*AW +: AW];
        return (s / 64'd64) * 64'd64;
    endfunction

    always @(posedge clk) begin : model
        int w;
        bit pop;
        if (!areset_n) begin
            q.delete();
            m_rr = 0; m_ar_pend = 1'b0; m_err = 1'b0;
        end else begin
            w   = exp_winner();
            pop = m_axi_rvalid && (q.size() > 0) && port_resp_ready[q[0]] && m_axi_rlast;
            if (m_axi_rvalid && q.size() == 0) m_err = 1'b1;
            if (pop) void'(q.pop_front());
            if (w >= 0) begin
                m_ar_pend = 1'b1;
                m_ar_addr = exp_addr(w);
                q.push_back(w);
                m_rr = (w + 1) % N;
            end else if (m_axi_arready) begin
                m_ar_pend = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        int w;
        logic [N-1:0] er, ev;
        if (chk_en) begin
            er = '0; ev = '0;
            w = exp_winner();
            if (w >= 0) er[w] = 1'b1;
            if (q.size() > 0 && m_axi_rvalid) ev[q[0]] = 1'b1;
            chk("req_ready", 64'(port_req_ready), 64'(er));
            chk("arvalid", 64'(m_axi_arvalid), 64'(m_ar_pend));
            if (m_ar_pend) chk("araddr", m_axi_araddr, m_ar_addr);
            chk("resp_valid", 64'(port_resp_valid), 64'(ev));
            chk("rready", 64'(m_axi_rready), 64'((q.size() > 0) && port_resp_ready[q[0]]));
            chk("outstanding", 64'(outstanding), 64'(q.size()));
            chk("idle", 64'(idle), 64'((q.size() == 0) && !m_ar_pend));
            chk("rresp_err", 64'(rresp_err), 64'(m_err));
            if (m_axi_rvalid) begin
                chk("resp_data", port_resp_data[63:0], m_axi_rdata[63:0]);
                chk("resp_last", 64'(port_resp_last), 64'(m_axi_rlast));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int bursts);
        for (int b = 0; b < bursts; b++) begin
            for (int k = 0; k < BL; k++) begin
                m_axi_rvalid = 1'b1;
                m_axi_rlast  = (k == BL - 1);
                m_axi_rdata  = {8{64'(b * 16 + k + 1)}};
                step();
            end
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
    endtask

    initial begin
        areset_n         = 1'b0;
        ctrl_addr_offset = 64'h1000;
        for (int p = 0; p < N; p++) port_req_addr[p*AW +: AW] = 64'h47 + 64'(p) * 64'h1000;
        port_req_valid  = 4'hF;
        port_resp_ready = 4'hF;
        m_axi_arready   = 1'b0;
        m_axi_rvalid    = 1'b0;
        m_axi_rdata     = '0;
        m_axi_rlast     = 1'b0;

        // Reset held with every request valid
        step();
        chk_en = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
            chk("rst_req_ready", 64'(port_req_ready), 64'd0);
            chk("rst_outstanding", 64'(outstanding), 64'd0);
            chk("rst_idle", 64'(idle), 64'd1);
            step();
        end

        // Continuous requests, arready high: rotation 0,1,2,3,0
        areset_n      = 1'b1;
        m_axi_arready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rr_grant", 64'(port_req_ready), 64'(4'b0001 << (k % 4)));
            if (k == 1) chk("araddr_offset", m_axi_araddr, 64'h1040);
            step();
        end
        port_req_valid = 4'h0;
        step();
        @(negedge clk);
        chk("outstanding_5", 64'(outstanding), 64'd5);
        chk("arlen", 64'(m_axi_arlen), 64'd3);
        step();
        drain(5);

        // AR stall: address held, no second grant until the handshake cycle
        port_req_valid = 4'b0100;
        m_axi_arready  = 1'b0;
        @(negedge clk);
        chk("stall_first_grant", 64'(port_req_ready), 64'b0100);
        step();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_araddr", m_axi_araddr, 64'h3040);
            chk("stall_no_grant", 64'(port_req_ready), 64'd0);
            chk("stall_outstanding", 64'(outstanding), 64'd1);
            step();
        end
        m_axi_arready = 1'b1;
        @(negedge clk);
        chk("handshake_grant", 64'(port_req_ready), 64'b0100);
        step();
        port_req_valid = 4'h0;
        @(negedge clk);
        chk("stall_outstanding_2", 64'(outstanding), 64'd2);
        step();
        drain(2);

        // Fill to the outstanding cap, then free exactly one slot
        port_req_valid = 4'hF;
        repeat (18) step();
        @(negedge clk);
        chk("full_outstanding", 64'(outstanding), 64'd16);
        chk("full_no_grant", 64'(port_req_ready), 64'd0);
        for (int k = 0; k < BL; k++) begin
            m_axi_rvalid = 1'b1;
            m_axi_rlast  = (k == BL - 1);
            m_axi_rdata  = {8{64'(k + 100)}};
            @(negedge clk);
            chk("full_pop_no_grant", 64'(port_req_ready), 64'd0);
            step();
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        @(negedge clk);
        chk("one_new_grant", 64'(port_req_ready), 64'b1000);
        chk("after_pop_outstanding", 64'(outstanding), 64'd15);
        step();
        @(negedge clk);
        chk("refull_no_grant", 64'(port_req_ready), 64'd0);
        chk("refull_outstanding", 64'(outstanding), 64'd16);
        port_req_valid = 4'h0;
        step();
        drain(16);

        // Burst routing: grant port 2 then port 1, four beats each
        port_req_valid = 4'b0100;
        step();
        port_req_valid = 4'b0010;
        step();
        port_req_valid = 4'h0;
        step();
        port_resp_ready = 4'b1011;
        m_axi_rvalid    = 1'b1;
        m_axi_rlast     = 1'b0;
        m_axi_rdata     = {8{64'hA0}};
        @(negedge clk);
        chk("bp_rready", 64'(m_axi_rready), 64'd0);
        chk("bp_resp_valid", 64'(port_resp_valid), 64'b0100);
        step();
        port_resp_ready = 4'hF;
        for (int k = 0; k < 2 * BL; k++) begin
            m_axi_rlast = (k == BL - 1) || (k == 2 * BL - 1);
            m_axi_rdata = {8{64'(k + 200)}};
            @(negedge clk);
            chk("route_resp_valid", 64'(port_resp_valid), (k < BL) ? 64'b0100 : 64'b0010);
            chk("route_rready", 64'(m_axi_rready), 64'd1);
            step();
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        @(negedge clk);
        chk("route_drained", 64'(outstanding), 64'd0);
        step();

        // Stray R beat with nothing outstanding
        m_axi_rvalid = 1'b1;
        m_axi_rlast  = 1'b1;
        @(negedge clk);
        chk("stray_rready", 64'(m_axi_rready), 64'd0);
        chk("stray_resp_valid", 64'(port_resp_valid), 64'd0);
        step();
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("err_sticky", 64'(rresp_err), 64'd1);
            step();
        end
        areset_n = 1'b0;
        step();
        areset_n = 1'b1;
        @(negedge clk);
        chk("err_cleared", 64'(rresp_err), 64'd0);
        step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
